// File: rtl/tia_phase_tracker_pkg.sv
// Shared types for the phi0 phase tracker: FSM state encoding and interval width helper.
// The encodings (HUNT=0, ACQUIRE=1, LOCKED=2) are visible to any bench that imports this package.
package tia_phase_tracker_pkg;

  localparam int unsigned StateW = 2;

  typedef enum logic [StateW-1:0] {
    StHunt    = 2'd0,
    StAcquire = 2'd1,
    StLocked  = 2'd2
  } state_e;

  // Interval counter saturates at divisor+1, so it needs room for that value.
  function automatic int unsigned ivl_width(input int unsigned divisor);
    return $clog2(divisor + 2);
  endfunction

endpackage

// File: rtl/tia_interval_counter.sv
// Rising-edge detector and saturating interval counter for phi_theta.
// interval is the count before this edge's update; timeout flags a saturated interval with no rise.
module tia_interval_counter #(
  parameter int unsigned DIVISOR = 3,
  parameter int unsigned IVL_W   = 3
) (
  input  logic             clk,
  input  logic             resphi0,
  input  logic             phi_theta,
  output logic             rise,
  output logic [IVL_W-1:0] interval,
  output logic             timeout
);

  localparam logic [IVL_W-1:0] IvlMax = IVL_W'(DIVISOR + 1);

  logic             prev_q;
  logic [IVL_W-1:0] ivl_q, ivl_d;

  // prev_q resets high so a phi_theta already high out of reset is not taken as a rise.
  always_ff @(posedge clk) begin
    if (resphi0) begin
      prev_q <= 1'b1;
      ivl_q  <= '0;
    end else begin
      prev_q <= phi_theta;
      ivl_q  <= ivl_d;
    end
  end

  // Edge detect and saturating interval update.
  always_comb begin
    rise = phi_theta & ~prev_q;
    if (rise) begin
      ivl_d = IVL_W'(1);
    end else if (ivl_q == IvlMax) begin
      ivl_d = ivl_q;
    end else begin
      ivl_d = ivl_q + IVL_W'(1);
    end
  end

  assign interval = ivl_q;
  assign timeout  = (ivl_q == IvlMax) && !rise;

endmodule

// File: rtl/tia_phase_tracker.sv
// Receive side of the phi0 divider: qualifies lock on phi_theta, recovers the color-clock phase
// within each CPU cycle, strobes and counts CPU cycles, flags period faults.
// Optional high-width check enabled by defining TIA_PHASE_TRACKER_DUTY_CHECK_EN.
module tia_phase_tracker
  import tia_phase_tracker_pkg::*;
#(
  parameter int unsigned DIVISOR    = 3,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             resphi0,
  input  logic             phi_theta,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             cpu_strobe,
  output logic [CNT_W-1:0] cpu_cycles,
  output logic             period_error,
  output logic             duty_error
);

  localparam int unsigned IvlW      = ivl_width(DIVISOR);
  localparam int unsigned GoodW     = $clog2(LOCK_COUNT + 1);
  localparam logic [1:0]  PhaseLast = 2'(DIVISOR - 1);

  logic            rise;
  logic [IvlW-1:0] interval;
  logic            timeout;
  logic            good_ivl;

  state_e             state_q, state_d;
  logic [GoodW-1:0]   good_q, good_d;
  logic               strobe_d, perr_d;
  logic               locked_q, strobe_q, perr_q;
  logic [1:0]         phase_q;
  logic [CNT_W-1:0]   cycles_q;

  tia_interval_counter #(
    .DIVISOR (DIVISOR),
    .IVL_W   (IvlW)
  ) u_interval (
    .clk       (clk),
    .resphi0   (resphi0),
    .phi_theta (phi_theta),
    .rise      (rise),
    .interval  (interval),
    .timeout   (timeout)
  );

  // Lock FSM next state, good-interval count and one-cycle event pulses.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    strobe_d = 1'b0;
    perr_d   = 1'b0;
    good_ivl = (interval == IvlW'(DIVISOR));
    unique case (state_q)
      StHunt: begin
        if (rise) begin
          state_d = StAcquire;
          good_d  = '0;
        end
      end
      StAcquire: begin
        if (rise) begin
          if (!good_ivl) begin
            good_d = '0;
          end else if (good_q == GoodW'(LOCK_COUNT - 1)) begin
            state_d  = StLocked;
            good_d   = '0;
            strobe_d = 1'b1;
          end else begin
            good_d = good_q + GoodW'(1);
          end
        end else if (timeout) begin
          state_d = StHunt;
        end
      end
      StLocked: begin
        if (rise) begin
          if (good_ivl) begin
            strobe_d = 1'b1;
          end else begin
            perr_d  = 1'b1;
            state_d = StAcquire;
            good_d  = '0;
          end
        end else if (timeout) begin
          perr_d  = 1'b1;
          state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase
  end

  // State and registered outputs; phase and cycle count only live while locked.
  always_ff @(posedge clk) begin
    if (resphi0) begin
      state_q  <= StHunt;
      good_q   <= '0;
      locked_q <= 1'b0;
      strobe_q <= 1'b0;
      perr_q   <= 1'b0;
      phase_q  <= 2'd0;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      good_q   <= good_d;
      locked_q <= (state_d == StLocked);
      strobe_q <= strobe_d;
      perr_q   <= perr_d;
      if (state_d != StLocked || rise || phase_q == PhaseLast) begin
        phase_q <= 2'd0;
      end else begin
        phase_q <= phase_q + 2'd1;
      end
      if (state_d != StLocked) begin
        cycles_q <= '0;
      end else if (strobe_d) begin
        cycles_q <= cycles_q + CNT_W'(1);
      end
    end
  end

  assign locked       = locked_q;
  assign phase        = phase_q;
  assign cpu_strobe   = strobe_q;
  assign cpu_cycles   = cycles_q;
  assign period_error = perr_q;

`ifdef TIA_PHASE_TRACKER_DUTY_CHECK_EN
  localparam logic [IvlW-1:0] HighMax = IvlW'(DIVISOR + 1);

  logic [IvlW-1:0] high_q;
  logic [IvlW-1:0] width_ref_q;
  logic            duty_q;

  // High-width measurement; reference taken at the rise that enters LOCKED.
  always_ff @(posedge clk) begin
    if (resphi0) begin
      high_q      <= '0;
      width_ref_q <= '0;
      duty_q      <= 1'b0;
    end else begin
      if (rise) begin
        high_q <= IvlW'(1);
      end else if (phi_theta && high_q != HighMax) begin
        high_q <= high_q + IvlW'(1);
      end
      duty_q <= 1'b0;
      if (state_d != StLocked) begin
        width_ref_q <= '0;
      end else if (state_q != StLocked && rise) begin
        width_ref_q <= high_q;
      end else if (rise && high_q != width_ref_q) begin
        duty_q <= 1'b1;
      end
    end
  end

  assign duty_error = duty_q;
`else
  assign duty_error = 1'b0;
`endif

endmodule
